// File: rtl/scan_code_ascii_decoder_if.sv
// Keyboard-side bundle for the scan-code decoder: scan byte strobe in, ASCII FIFO head
// and modifier status out. The master drives bytes and pops; the slave is the decoder.
interface scan_code_ascii_decoder_if;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic [7:0] ascii_data;
  logic       ascii_empty;
  logic       ascii_rd;
  logic       overflow;
  logic       shift_active;
  logic       caps_lock;

  modport master (
    output scan_code, scan_valid, ascii_rd,
    input  ascii_data, ascii_empty, overflow, shift_active, caps_lock
  );

  modport slave (
    input  scan_code, scan_valid, ascii_rd,
    output ascii_data, ascii_empty, overflow, shift_active, caps_lock
  );
endinterface

// File: rtl/scan_code_ascii_decoder.sv
// PS/2 set-2 scan-code decoder: tracks break/extended prefixes and shift/caps state,
// translates make codes to ASCII and queues them in a show-ahead FIFO.
module scan_code_ascii_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                        fpga_clock,
  input  logic                        reset,
  scan_code_ascii_decoder_if.slave    kbd
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } state_t;

  typedef struct packed {
    logic       hit;
    logic       letter;
    logic [7:0] ch;
  } xlat_t;

  localparam int               CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0]       SC_BREAK  = 8'hF0;
  localparam logic [7:0]       SC_EXT    = 8'hE0;
  localparam logic [7:0]       SC_LSHIFT = 8'h12;
  localparam logic [7:0]       SC_RSHIFT = 8'h59;
  localparam logic [7:0]       SC_CAPS   = 8'h58;
  localparam logic [7:0]       SC_ENTER  = 8'h5A;

  // Letters return their lowercase code; case is folded in by the caller.
  function automatic xlat_t lookup(input logic [7:0] code);
    xlat_t r;
    r = '0;
    case (code)
      8'h1C: r = {1'b1, 1'b1, 8'h61};
      8'h32: r = {1'b1, 1'b1, 8'h62};
      8'h21: r = {1'b1, 1'b1, 8'h63};
      8'h23: r = {1'b1, 1'b1, 8'h64};
      8'h24: r = {1'b1, 1'b1, 8'h65};
      8'h2B: r = {1'b1, 1'b1, 8'h66};
      8'h34: r = {1'b1, 1'b1, 8'h67};
      8'h33: r = {1'b1, 1'b1, 8'h68};
      8'h43: r = {1'b1, 1'b1, 8'h69};
      8'h3B: r = {1'b1, 1'b1, 8'h6A};
      8'h42: r = {1'b1, 1'b1, 8'h6B};
      8'h4B: r = {1'b1, 1'b1, 8'h6C};
      8'h3A: r = {1'b1, 1'b1, 8'h6D};
      8'h31: r = {1'b1, 1'b1, 8'h6E};
      8'h44: r = {1'b1, 1'b1, 8'h6F};
      8'h4D: r = {1'b1, 1'b1, 8'h70};
      8'h15: r = {1'b1, 1'b1, 8'h71};
      8'h2D: r = {1'b1, 1'b1, 8'h72};
      8'h1B: r = {1'b1, 1'b1, 8'h73};
      8'h2C: r = {1'b1, 1'b1, 8'h74};
      8'h3C: r = {1'b1, 1'b1, 8'h75};
      8'h2A: r = {1'b1, 1'b1, 8'h76};
      8'h1D: r = {1'b1, 1'b1, 8'h77};
      8'h22: r = {1'b1, 1'b1, 8'h78};
      8'h35: r = {1'b1, 1'b1, 8'h79};
      8'h1A: r = {1'b1, 1'b1, 8'h7A};
      8'h45: r = {1'b1, 1'b0, 8'h30};
      8'h16: r = {1'b1, 1'b0, 8'h31};
      8'h1E: r = {1'b1, 1'b0, 8'h32};
      8'h26: r = {1'b1, 1'b0, 8'h33};
      8'h25: r = {1'b1, 1'b0, 8'h34};
      8'h2E: r = {1'b1, 1'b0, 8'h35};
      8'h36: r = {1'b1, 1'b0, 8'h36};
      8'h3D: r = {1'b1, 1'b0, 8'h37};
      8'h3E: r = {1'b1, 1'b0, 8'h38};
      8'h46: r = {1'b1, 1'b0, 8'h39};
      8'h29: r = {1'b1, 1'b0, 8'h20};
      8'h5A: r = {1'b1, 1'b0, 8'h0D};
      8'h66: r = {1'b1, 1'b0, 8'h08};
      8'h0D: r = {1'b1, 1'b0, 8'h09};
      default: r = '0;
    endcase
    return r;
  endfunction

  state_t            state_q, state_d;
  logic              shift_l_q, shift_l_d;
  logic              shift_r_q, shift_r_d;
  logic              caps_q, caps_d;
  logic              caps_held_q, caps_held_d;
  logic              wr_pend_q, wr_pend_d;
  logic [7:0]        wr_char_q, wr_char_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        mem_q [FIFO_DEPTH];

  xlat_t             xl;
  logic              upper;
  logic              fifo_full;
  logic              fifo_empty;
  logic              do_rd;
  logic              wr_en;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    shift_l_d   = shift_l_q;
    shift_r_d   = shift_r_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    wr_pend_d   = 1'b0;
    wr_char_d   = wr_char_q;
    xl          = lookup(kbd.scan_code);
    upper       = (shift_l_q | shift_r_q) ^ caps_q;

    if (kbd.scan_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (kbd.scan_code == SC_BREAK) begin
            state_d = ST_BRK;
          end else if (kbd.scan_code == SC_EXT) begin
            state_d = ST_EXT;
          end else begin
            case (kbd.scan_code)
              SC_LSHIFT: shift_l_d = 1'b1;
              SC_RSHIFT: shift_r_d = 1'b1;
              SC_CAPS: begin
                // Holding caps-lock auto-repeats its make code; toggle only on the first.
                if (!caps_held_q) caps_d = ~caps_q;
                caps_held_d = 1'b1;
              end
              default: begin
                if (xl.hit) begin
                  wr_pend_d = 1'b1;
                  wr_char_d = (xl.letter && upper) ? (xl.ch - 8'h20) : xl.ch;
                end
              end
            endcase
          end
        end
        ST_BRK: begin
          case (kbd.scan_code)
            SC_LSHIFT: shift_l_d   = 1'b0;
            SC_RSHIFT: shift_r_d   = 1'b0;
            SC_CAPS:   caps_held_d = 1'b0;
            default:   ;
          endcase
          state_d = ST_IDLE;
        end
        ST_EXT: begin
          if (kbd.scan_code == SC_BREAK) begin
            state_d = ST_EXT_BRK;
          end else begin
            if (kbd.scan_code == SC_ENTER) begin
              wr_pend_d = 1'b1;
              wr_char_d = 8'h0D;
            end
            state_d = ST_IDLE;
          end
        end
        ST_EXT_BRK: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // A read of an empty FIFO is ignored; a full FIFO accepts a write only alongside a read.
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == DEPTH_C);
    do_rd      = kbd.ascii_rd && !fifo_empty;
    wr_en      = wr_pend_q && (!fifo_full || do_rd);
    overflow_d = overflow_q | (wr_pend_q && fifo_full && !do_rd);
    wr_ptr_d   = wr_en ? (wr_ptr_q + ADDR_W'(1)) : wr_ptr_q;
    rd_ptr_d   = do_rd ? (rd_ptr_q + ADDR_W'(1)) : rd_ptr_q;
    count_d    = count_q + CNT_W'(wr_en) - CNT_W'(do_rd);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge fpga_clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shift_l_q   <= 1'b0;
      shift_r_q   <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      wr_pend_q   <= 1'b0;
      wr_char_q   <= 8'h00;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_l_q   <= shift_l_d;
      shift_r_q   <= shift_r_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
      wr_pend_q   <= wr_pend_d;
      wr_char_q   <= wr_char_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // NOTE: storage is not reset; the head output is forced to zero while empty instead.
  always_ff @(posedge fpga_clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_char_q;
  end

  assign kbd.ascii_empty  = fifo_empty;
  assign kbd.ascii_data   = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign kbd.overflow     = overflow_q;
  assign kbd.shift_active = shift_l_q | shift_r_q;
  assign kbd.caps_lock    = caps_q;

endmodule

// File: tb/tb_scan_code_ascii_decoder.sv
// Bench for scan_code_ascii_decoder: vector table, directed corner sequences and
// random byte streams checked against a queue-based keyboard model.
module tb_scan_code_ascii_decoder;
  localparam int DEPTH = 8;

  logic fpga_clock = 1'b0;
  logic reset      = 1'b1;

  scan_code_ascii_decoder_if kbd ();

  scan_code_ascii_decoder #(.FIFO_DEPTH(DEPTH), .ADDR_W(3)) dut (
    .fpga_clock (fpga_clock),
    .reset      (reset),
    .kbd        (kbd)
  );

  always #5 fpga_clock = ~fpga_clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: prefix flags, modifier flags, pending char, FIFO as a queue.
  byte unsigned m_q[$];
  int           m_pend;
  bit           m_f0, m_e0, m_shl, m_shr, m_caps, m_held, m_ovf;

  byte unsigned letter_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                     8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                     8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                     8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  byte unsigned digit_codes[10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                     8'h3D, 8'h3E, 8'h46};
  byte unsigned pool[20]         = '{8'h12, 8'h59, 8'h58, 8'hF0, 8'hE0, 8'h1C, 8'h32,
                                     8'h2C, 8'h3C, 8'h45, 8'h16, 8'h29, 8'h5A, 8'h66,
                                     8'h0D, 8'h75, 8'hE1, 8'hAA, 8'hFA, 8'h43};

  function automatic int model_char(byte unsigned code, bit upper);
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == code) return (upper ? 'h41 : 'h61) + i;
    for (int i = 0; i < 10; i++)
      if (digit_codes[i] == code) return 'h30 + i;
    case (code)
      8'h29:   return 'h20;
      8'h5A:   return 'h0D;
      8'h66:   return 'h08;
      8'h0D:   return 'h09;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pend = -1;
    {m_f0, m_e0, m_shl, m_shr, m_caps, m_held, m_ovf} = '0;
  endtask

  task automatic model_byte(byte unsigned c);
    if (m_e0 && m_f0) begin
      m_e0 = 0; m_f0 = 0;
    end else if (m_f0) begin
      if (c == 8'h12) m_shl = 0;
      if (c == 8'h59) m_shr = 0;
      if (c == 8'h58) m_held = 0;
      m_f0 = 0;
    end else if (m_e0) begin
      if (c == 8'hF0) m_f0 = 1;
      else begin
        if (c == 8'h5A) m_pend = 'h0D;
        m_e0 = 0;
      end
    end else if (c == 8'hF0) m_f0 = 1;
    else if (c == 8'hE0) m_e0 = 1;
    else if (c == 8'h12) m_shl = 1;
    else if (c == 8'h59) m_shr = 1;
    else if (c == 8'h58) begin
      if (!m_held) m_caps = !m_caps;
      m_held = 1;
    end else m_pend = model_char(c, (m_shl | m_shr) ^ m_caps);
  endtask

  task automatic model_step(bit v, byte unsigned c, bit r);
    if (r && m_q.size() > 0) void'(m_q.pop_front());
    if (m_pend >= 0) begin
      if (m_q.size() < DEPTH) m_q.push_back(byte'(m_pend));
      else m_ovf = 1;
    end
    m_pend = -1;
    if (v) model_byte(c);
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("model_empty", 32'(kbd.ascii_empty), 32'(m_q.size() == 0));
    check("model_data", 32'(kbd.ascii_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
    check("model_overflow", 32'(kbd.overflow), 32'(m_ovf));
    check("model_shift", 32'(kbd.shift_active), 32'(m_shl | m_shr));
    check("model_caps", 32'(kbd.caps_lock), 32'(m_caps));
  endtask

  // Called at a falling edge; applies inputs across one rising edge, samples at the next fall.
  task automatic tick(bit v, byte unsigned c, bit r);
    kbd.scan_valid = v;
    kbd.scan_code  = c;
    kbd.ascii_rd   = r;
    @(negedge fpga_clock);
    model_step(v, c, r);
    compare_model();
  endtask

  task automatic send(byte unsigned c);
    tick(1'b1, c, 1'b0);
  endtask

  task automatic idle();
    tick(1'b0, 8'h00, 1'b0);
  endtask

  task automatic pop();
    tick(1'b0, 8'h00, 1'b1);
  endtask

  typedef struct {
    bit         v;
    logic [7:0] code;
    bit         rd;
    bit         e_empty;
    logic [7:0] e_data;
    bit         e_shift;
    bit         e_caps;
  } vec_t;

  vec_t         tbl[16];
  byte unsigned exp_list[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Letters D I C K without reads, drain, then shifted B and unshifted b.
    tbl[0]  = '{1'b1, 8'h23, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 8'h43, 1'b0, 1'b0, 8'h64, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 8'h21, 1'b0, 1'b0, 8'h64, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 8'h42, 1'b0, 1'b0, 8'h64, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h64, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h69, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h63, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h6B, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 8'h12, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 8'h32, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 8'hF0, 1'b1, 1'b0, 8'h42, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 8'h12, 1'b0, 1'b0, 8'h42, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 8'h32, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h62, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};

    kbd.scan_valid = 1'b0;
    kbd.scan_code  = 8'h00;
    kbd.ascii_rd   = 1'b0;
    model_reset();
    repeat (2) @(negedge fpga_clock);
    check("reset_empty", 32'(kbd.ascii_empty), 32'd1);
    check("reset_data", 32'(kbd.ascii_data), 32'h0);
    check("reset_overflow", 32'(kbd.overflow), 32'd0);
    check("reset_shift", 32'(kbd.shift_active), 32'd0);
    check("reset_caps", 32'(kbd.caps_lock), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      tick(tbl[i].v, tbl[i].code, tbl[i].rd);
      check($sformatf("tbl%0d_empty", i), 32'(kbd.ascii_empty), 32'(tbl[i].e_empty));
      check($sformatf("tbl%0d_data", i), 32'(kbd.ascii_data), 32'(tbl[i].e_data));
      check($sformatf("tbl%0d_shift", i), 32'(kbd.shift_active), 32'(tbl[i].e_shift));
      check($sformatf("tbl%0d_caps", i), 32'(kbd.caps_lock), 32'(tbl[i].e_caps));
    end

    // Caps-lock typematic toggles once; shift XOR caps selects case.
    send(8'h58);
    send(8'h58);
    check("caps_repeat", 32'(kbd.caps_lock), 32'd1);
    send(8'hF0); send(8'h58); send(8'h3C); idle();
    check("caps_upper_u", 32'(kbd.ascii_data), 32'h55);
    send(8'h12); send(8'h3C); idle();
    pop();
    check("shift_caps_lower_u", 32'(kbd.ascii_data), 32'h75);
    pop();
    check("caps_drained", 32'(kbd.ascii_empty), 32'd1);

    // Extended sequences: only E0 5A emits, FSM ends in IDLE.
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'h5A);
    send(8'hF0); send(8'h2C); idle();
    check("ext_enter", 32'(kbd.ascii_data), 32'h0D);
    pop();
    check("ext_only_one", 32'(kbd.ascii_empty), 32'd1);
    send(8'h2C); idle();
    check("ext_back_idle", 32'(kbd.ascii_data), 32'h74);
    pop();

    // Release shift, toggle caps off.
    send(8'hF0); send(8'h12);
    send(8'h58); send(8'hF0); send(8'h58); idle();
    check("mods_clear_shift", 32'(kbd.shift_active), 32'd0);
    check("mods_clear_caps", 32'(kbd.caps_lock), 32'd0);

    // FIFO full, simultaneous read+write, then overflow.
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
    send(8'h24); send(8'h2B); send(8'h34); send(8'h33); idle();
    check("full_no_overflow", 32'(kbd.overflow), 32'd0);
    check("full_head", 32'(kbd.ascii_data), 32'h61);
    send(8'h43);
    pop();
    check("full_rdwr_overflow", 32'(kbd.overflow), 32'd0);
    check("full_rdwr_head", 32'(kbd.ascii_data), 32'h62);
    send(8'h3B); idle();
    check("overflow_set", 32'(kbd.overflow), 32'd1);
    check("overflow_head", 32'(kbd.ascii_data), 32'h62);
    send(8'h42);
    pop();
    check("overflow_sticky", 32'(kbd.overflow), 32'd1);
    exp_list = '{8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69, 8'h6B};
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d", i), 32'(kbd.ascii_data), 32'(exp_list[i]));
      pop();
    end
    check("drain_empty", 32'(kbd.ascii_empty), 32'd1);
    send(8'h1C); idle();

    // Asynchronous reset after a break prefix.
    send(8'hF0);
    kbd.scan_valid = 1'b0;
    kbd.scan_code  = 8'h00;
    kbd.ascii_rd   = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_rst_empty", 32'(kbd.ascii_empty), 32'd1);
    check("async_rst_data", 32'(kbd.ascii_data), 32'h0);
    check("async_rst_overflow", 32'(kbd.overflow), 32'd0);
    #1 reset = 1'b0;
    model_reset();
    @(negedge fpga_clock);
    compare_model();
    send(8'h2C); idle();
    check("prefix_discarded", 32'(kbd.ascii_data), 32'h74);

    // Random byte streams with random pops.
    for (int n = 0; n < 600; n++) begin
      tick(($urandom_range(3) != 0), pool[$urandom_range(19)], ($urandom_range(2) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
